// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM master: opcodes, FSM encoding and frame lengths.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int SEL_LEN = 2;
  localparam int CMD_LEN = 10;
  localparam int RD_LEN  = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } spi_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register with parallel load, MSB-first serial in/out and a saturating bit counter.
module spi_shift_reg
  import spi_ram_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     pdin,
  input  logic             shift,
  input  logic             sin,
  input  logic             cnt_clr,
  input  logic             cnt_en,
  output logic             sout,
  output logic [W-1:0]     pout,
  output logic [CNT_W-1:0] cnt
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (!rst_n)      q <= '0;
    else if (load)   q <= pdin;
    else if (shift)  q <= {q[W-2:0], sin};
  end

  // Saturates instead of wrapping so a long stay in one state cannot alias a compare.
  always_ff @(posedge clk) begin
    if (!rst_n)                    cnt <= '0;
    else if (cnt_clr)              cnt <= '0;
    else if (cnt_en && cnt != '1)  cnt <= cnt + 1'b1;
  end

  assign sout = q[W-1];
  // Includes the bit arriving this cycle, so the final byte is available on the last sample edge.
  assign pout = {q[W-2:0], sin};

endmodule

// File: rtl/spi_ram_master.sv
// SPI master issuing 10-bit RAM commands; read-data frames collect an 8-bit MISO response.
//   state    | meaning
//   ST_IDLE  | SS_n high, ready for a command
//   ST_SEL   | SS_n low, MOSI holds cmd[9] for SEL_LEN cycles
//   ST_SHIFT | command bits out on MOSI, MSB first
//   ST_WAIT  | RD_GAP turnaround cycles before the response
//   ST_RECV  | sample RD_LEN response bits from MISO
//   ST_DONE  | SS_n high one cycle; read data published here
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int RD_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  spi_state_e state, state_nxt;
  logic [1:0]         op_q;
  logic               accept;
  logic               rd_done;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   rx_cnt;
  logic [RD_LEN-1:0]  rx_pout;
  logic [CMD_LEN-1:0] tx_pout_unused;
  logic               rx_sout_unused;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rd_done   = (state == ST_RECV) && (state_nxt == ST_DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SEL;
      ST_SEL:   if (cnt == CNT_W'(SEL_LEN - 1)) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_W'(CMD_LEN - 1))
                  state_nxt = (op_q == OP_RD_DATA) ? ST_WAIT : ST_DONE;
      ST_WAIT:  if (cnt == CNT_W'(RD_GAP - 1)) state_nxt = ST_RECV;
      ST_RECV:  if (rx_cnt == CNT_W'(RD_LEN - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // TX zero-fills while shifting, so MOSI falls back to 0 once the command is out.
  spi_shift_reg #(.W(CMD_LEN)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .pdin    (cmd_data),
    .shift   (state == ST_SHIFT),
    .sin     (1'b0),
    .cnt_clr (state_nxt != state),
    .cnt_en  (1'b1),
    .sout    (MOSI),
    .pout    (tx_pout_unused),
    .cnt     (cnt)
  );

  spi_shift_reg #(.W(RD_LEN)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .pdin    ('0),
    .shift   (state == ST_RECV),
    .sin     (MISO),
    .cnt_clr (accept),
    .cnt_en  (state == ST_RECV),
    .sout    (rx_sout_unused),
    .pout    (rx_pout),
    .cnt     (rx_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_WR_ADDR;
      SS_n     <= 1'b1;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      if (accept) op_q <= cmd_data[9:8];
      SS_n     <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
      busy     <= (state_nxt != ST_IDLE);
      rd_valid <= rd_done;
      if (rd_done) rd_data <= rx_pout;
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench: two masters (RD_GAP 2 and 4) against a frame-level timing model.
module tb_spi_ram_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] cmd_data;
  logic       cmd_valid_a, cmd_valid_b;
  logic       miso;

  logic       rdy_a, rv_a, busy_a, ss_a, mosi_a;
  logic [7:0] rd_a;
  logic       rdy_b, rv_b, busy_b, ss_b, mosi_b;
  logic [7:0] rd_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rd_a = 8'h00;
  logic [7:0] exp_rd_b = 8'h00;

  always #5 clk = ~clk;

  spi_ram_master dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid_a),
    .cmd_ready(rdy_a), .rd_data(rd_a), .rd_valid(rv_a), .busy(busy_a),
    .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso)
  );

  spi_ram_master #(.RD_GAP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid_b),
    .cmd_ready(rdy_b), .rd_data(rd_b), .rd_valid(rv_b), .busy(busy_b),
    .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso)
  );

  // One frame, edge 0 being the next rising edge. Samples after every edge up to the first IDLE cycle.
  task automatic run_frame(input int which, input logic [9:0] cmd, input logic [7:0] resp,
                           input bit noise, input bit chain, input logic [9:0] next_cmd);
    int   gap   = (which != 0) ? 4 : 2;
    bit   is_rd = (cmd[9:8] == 2'b11);
    int   low_len;
    int   j;
    logic e_ss, e_mosi, e_rv, e_busy, e_rdy;
    logic [7:0] e_rd;
    logic o_ss, o_mosi, o_rv, o_busy, o_rdy;
    logic [7:0] o_rd;
    low_len = is_rd ? 12 + gap + 8 : 12;

    o_rdy = (which != 0) ? rdy_b : rdy_a;
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready cmd=%h got %b exp 1", cmd, o_rdy);
    end
    @(posedge clk);
    for (int k = 0; k <= low_len + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (chain) cmd_data = next_cmd;
        else begin
          cmd_valid_a = 1'b0;
          cmd_valid_b = 1'b0;
          cmd_data    = 10'($urandom);
        end
      end
      e_ss   = (k < low_len) ? 1'b0 : 1'b1;
      e_mosi = (k < 2) ? cmd[9] : (k < 12) ? cmd[11-k] : 1'b0;
      e_rv   = is_rd && (k == low_len);
      e_busy = (k <= low_len);
      e_rdy  = (k == low_len + 1);
      if (is_rd && k == low_len) begin
        if (which != 0) exp_rd_b = resp;
        else            exp_rd_a = resp;
      end
      e_rd = (which != 0) ? exp_rd_b : exp_rd_a;

      o_ss   = (which != 0) ? ss_b   : ss_a;
      o_mosi = (which != 0) ? mosi_b : mosi_a;
      o_rv   = (which != 0) ? rv_b   : rv_a;
      o_busy = (which != 0) ? busy_b : busy_a;
      o_rdy  = (which != 0) ? rdy_b  : rdy_a;
      o_rd   = (which != 0) ? rd_b   : rd_a;

      checks++;
      if (o_ss !== e_ss) begin
        errors++;
        $display("FAIL ss_n cmd=%h edge=%0d got %b exp %b", cmd, k, o_ss, e_ss);
      end
      checks++;
      if (o_mosi !== e_mosi) begin
        errors++;
        $display("FAIL mosi cmd=%h edge=%0d got %b exp %b", cmd, k, o_mosi, e_mosi);
      end
      checks++;
      if (o_rv !== e_rv) begin
        errors++;
        $display("FAIL rd_valid cmd=%h edge=%0d got %b exp %b", cmd, k, o_rv, e_rv);
      end
      checks++;
      if (o_busy !== e_busy) begin
        errors++;
        $display("FAIL busy cmd=%h edge=%0d got %b exp %b", cmd, k, o_busy, e_busy);
      end
      checks++;
      if (o_rdy !== e_rdy) begin
        errors++;
        $display("FAIL cmd_ready cmd=%h edge=%0d got %b exp %b", cmd, k, o_rdy, e_rdy);
      end
      checks++;
      if (o_rd !== e_rd) begin
        errors++;
        $display("FAIL rd_data cmd=%h edge=%0d got %h exp %h", cmd, k, o_rd, e_rd);
      end

      // Response bit j is sampled on edge 13+gap+j, so it is driven right after edge 12+gap+j.
      j = k - (12 + gap);
      if (is_rd && j >= 0 && j < 8) miso = resp[7-j];
      else                          miso = noise ? 1'($urandom) : 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    cmd_valid_a = 1'b1;
    cmd_valid_b = 1'b0;
    cmd_data    = 10'h0A5;
    miso        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      miso = 1'($urandom);
      checks++;
      if ({ss_a, mosi_a, rv_a, busy_a, rdy_a} !== 5'b10001) begin
        errors++;
        $display("FAIL reset_ctrl cyc=%0d got %b exp 10001", i, {ss_a, mosi_a, rv_a, busy_a, rdy_a});
      end
      checks++;
      if (rd_a !== 8'h00 || ss_b !== 1'b1) begin
        errors++;
        $display("FAIL reset_data cyc=%0d got rd=%h ss_b=%b exp rd=00 ss_b=1", i, rd_a, ss_b);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write_addr();
    run_frame(0, 10'h0A5, 8'h00, 1'b1, 1'b0, 10'h000);
  endtask

  task automatic test_back_to_back();
    cmd_data    = 10'h15A;
    cmd_valid_a = 1'b1;
    run_frame(0, 10'h15A, 8'h00, 1'b1, 1'b1, 10'h2A5);
    run_frame(0, 10'h2A5, 8'h00, 1'b1, 1'b0, 10'h000);
  endtask

  task automatic test_read_data();
    cmd_data    = 10'h300;
    cmd_valid_a = 1'b1;
    run_frame(0, 10'h300, 8'h5A, 1'b1, 1'b0, 10'h000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      miso = 1'($urandom);
      checks++;
      if (rd_a !== 8'h5A || rv_a !== 1'b0) begin
        errors++;
        $display("FAIL rd_hold cyc=%0d got rd=%h rv=%b exp rd=5a rv=0", i, rd_a, rv_a);
      end
    end
  endtask

  task automatic test_read_gap4();
    cmd_data    = 10'h3E1;
    cmd_valid_b = 1'b1;
    run_frame(1, 10'h3E1, 8'hC3, 1'b1, 1'b0, 10'h000);
  endtask

  task automatic test_mid_reset();
    cmd_data    = 10'h3C7;
    cmd_valid_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      cmd_valid_a = 1'b0;
      miso = 1'($urandom);
    end
    checks++;
    if (ss_a !== 1'b0 || rd_a !== exp_rd_a) begin
      errors++;
      $display("FAIL pre_reset got ss=%b rd=%h exp ss=0 rd=%h", ss_a, rd_a, exp_rd_a);
    end
    rst_n = 1'b0;
    exp_rd_a = 8'h00;
    exp_rd_b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      miso = 1'($urandom);
      checks++;
      if ({ss_a, mosi_a, rv_a, busy_a, rdy_a} !== 5'b10001) begin
        errors++;
        $display("FAIL midreset_ctrl cyc=%0d got %b exp 10001", i, {ss_a, mosi_a, rv_a, busy_a, rdy_a});
      end
      checks++;
      if (rd_a !== 8'h00) begin
        errors++;
        $display("FAIL midreset_rd cyc=%0d got %h exp 00", i, rd_a);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int         which;
    logic [9:0] cmd;
    logic [7:0] resp;
    for (int n = 0; n < 16; n++) begin
      which = int'($urandom_range(0, 1));
      cmd   = 10'($urandom);
      if (n % 3 == 0) cmd[9:8] = 2'b11;
      resp  = 8'($urandom);
      cmd_data = cmd;
      if (which != 0) cmd_valid_b = 1'b1;
      else            cmd_valid_a = 1'b1;
      run_frame(which, cmd, resp, 1'b1, 1'b0, 10'h000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_write_addr();
    test_back_to_back();
    test_read_data();
    test_read_gap4();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_master.md
# spi_ram_master

Single-channel SPI master that issues RAM commands to the SPI slave/RAM subsystem on the shared system clock. It accepts 10-bit command words on a valid/ready interface and drives SS_n and MOSI to the slave. For read-data commands it also collects the 8-bit response from MISO and returns it with a one-cycle valid pulse. It sits directly upstream of the SPI slave wrapper and is the test/host-side driver of that subsystem.

## Interface
- RD_GAP, default 2: idle cycles after the last command bit before the first MISO sample; covers slave and RAM turnaround (range 1..15).
- clk  in  1  system clock; all logic on rising edge; also the slave's clock.
- rst_n  in  1  synchronous, active-low reset.
- cmd_data  in  10  command word: [9:8] opcode, [7:0] address or data.
- cmd_valid  in  1  cmd_data valid.
- cmd_ready  out  1  high only in IDLE; a command is accepted on a rising edge with cmd_valid && cmd_ready.
- rd_data  out  8  response byte; held until the next read completes.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- busy  out  1  high from acceptance until back in IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to the slave, MSB first.
- MISO  in  1  serial data from the slave, MSB first.

## Operation
- Opcodes: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- States: IDLE, SEL, SHIFT, WAIT, RECV, DONE.
- IDLE: SS_n=1, MOSI=0. On acceptance, latch cmd_data into the shift register, clear the counter, and go to SEL.
- SEL, 2 cycles: SS_n=0, MOSI=cmd[9] (the slave's read/write select bit, held through its command-check cycle). Then go to SHIFT.
- SHIFT, 10 cycles: SS_n=0, MOSI=cmd[9-i] for i=0..9.
- After SHIFT:
  - Opcode 11 goes to WAIT.
  - All other opcodes go to DONE.
- WAIT, RD_GAP cycles: SS_n=0, MOSI=0. Then go to RECV.
- RECV, 8 cycles: SS_n=0, MOSI=0. Sample MISO on each rising edge into the receive shift register, MSB first.
- DONE, 1 cycle: SS_n=1, MOSI=0.
  - After a read-data frame, load rd_data and pulse rd_valid in this cycle.
  - Then go to IDLE.
- The bit counter is 4 bits. It clears on every state change and never wraps inside a state.
- cmd_data is ignored while busy. A held cmd_valid is accepted on the first IDLE edge, which gives back-to-back frames with exactly one SS_n-high cycle (DONE) between them, plus IDLE.

## Timing
- Reset values: SS_n=1, MOSI=0, rd_data=0, rd_valid=0, busy=0. cmd_ready is 1 whenever the state is IDLE, including during reset.
- Reset asserted mid-frame: on the next edge, SS_n=1, state=IDLE, and no rd_valid. rd_data is cleared.
- All outputs except cmd_ready are registered.
- Acceptance at edge 0:
  - SS_n is low from edge 0 through edge 12 for write and read-address frames (12 cycles low).
  - For read-data frames, SS_n is low for 12+RD_GAP+8 cycles (22 at default).
  - rd_valid rises at edge 12+RD_GAP+8 (edge 22 at default).
  - cmd_ready returns one cycle after DONE.
- MISO is sampled only in RECV. MISO activity at any other time has no effect.

## Structure
- Shared package spi_ram_pkg holds:
  - the opcode localparams (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA);
  - the state encoding;
  - the constants SEL_LEN=2, CMD_LEN=10, RD_LEN=8.
- One natural sub-module: spi_shift_reg, a parallel-load / serial-out and serial-in / parallel-out register with a bit counter, instantiated once for TX and once for RX.
- Top-level FSM and handshake stay in spi_ram_master.

## Test plan
- Reset with cmd_valid high -> SS_n=1, MOSI=0, rd_valid=0, busy=0 throughout; the first accept happens the first edge after rst_n=1.
- Write address 0x0A5 -> SS_n low for 12 cycles; MOSI sequence 0,0, then 0,0,1,0,1,0,0,1,0,1; no rd_valid.
- Frame pair write-data 0x15A then read-address 0x2A5, checked end to end through the slave/RAM -> exactly one SS_n-high DONE cycle between them; the second frame's MOSI starts with 1,1.
- Read data 0x300 with the end-to-end slave returning 0x5A -> rd_valid rises at edge 22, rd_data=0x5A and is held afterwards.
- Read data with RD_GAP=4 and a MISO model driving 0xC3 -> rd_valid at edge 24, rd_data=0xC3; MISO toggling outside RECV has no effect.
- rst_n low at cycle 6 of a read-data frame -> SS_n=1 on the next edge, no rd_valid pulse, rd_data=0, cmd_ready=1.
